// File: rtl/layer_pkg.sv
// rtl/layer_pkg.sv - shared FC-layer constants and feeder state encoding
package layer_pkg;

    localparam int K_LEN_DEF    = 784;
    localparam int N_OUT_DEF    = 10;
    localparam int MAC_PIPE_LAT = 2;
    // mac_valid_o to visible MAC result: internal pipe plus the capture register
    localparam int RES_LAT      = MAC_PIPE_LAT + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RD,
        ST_VLD,
        ST_W1,
        ST_W2,
        ST_TAIL
    } feeder_state_e;

endpackage

// File: rtl/mac_feeder_dly.sv
// rtl/mac_feeder_dly.sv - W-bit by D-cycle shift register with synchronous clear
module mac_feeder_dly #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [D];
    logic [W-1:0] pipe_d [D];

    always_comb begin
        pipe_d[0] = d_i;
        for (int i = 1; i < D; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < D; i++) begin
            if (rst_i) begin
                pipe_q[i] <= '0;
            end else begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign q_o = pipe_q[D-1];

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - FC-layer MAC input sequencer; MAC_FEEDER_PERF_EN adds perf_cycles_o
module mac_feeder
    import layer_pkg::*;
#(
    parameter int K_LEN  = K_LEN_DEF,
    parameter int N_OUT  = N_OUT_DEF,
    parameter int IMG_AW = (K_LEN > 1) ? $clog2(K_LEN) : 1,
    parameter int W_AW   = (K_LEN * N_OUT > 1) ? $clog2(K_LEN * N_OUT) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              img_rd_o,
    output logic [IMG_AW-1:0] img_addr_o,
    input  logic [7:0]        img_q_i,
    output logic              w_rd_o,
    output logic [W_AW-1:0]   w_addr_o,
    input  logic [7:0]        w_q_i,
    output logic              mac_en_o,
    output logic              mac_valid_o,
    output logic              mac_clear_o,
    output logic [7:0]        image_data_o,
    output logic [7:0]        weight_data_o,
`ifdef MAC_FEEDER_PERF_EN
    output logic [31:0]       perf_cycles_o,
`endif
    output logic              res_valid_o,
    output logic [3:0]        res_idx_o
);

    feeder_state_e     state_q, state_d;
    logic [IMG_AW-1:0] k_q, k_d;
    logic [3:0]        o_q, o_d;
    logic [W_AW-1:0]   w_addr_q, w_addr_d;
    logic              busy_q, busy_d;
    logic              mac_clear_q, mac_clear_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_valid_q, mac_valid_d;
    logic [3:0]        vld_idx_q, vld_idx_d;
    logic [4:0]        res_dly;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        o_d      = o_q;
        w_addr_d = w_addr_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_CLR;
                    k_d      = '0;
                    o_d      = '0;
                    w_addr_d = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_CLR: state_d = ST_RD;
            ST_RD: begin
                // weight address keeps running across neurons, giving o*K_LEN+k without a multiply
                w_addr_d = w_addr_q + W_AW'(1);
                if (k_q == IMG_AW'(K_LEN - 1)) begin
                    k_d     = '0;
                    state_d = ST_VLD;
                end else begin
                    k_d = k_q + IMG_AW'(1);
                end
            end
            ST_VLD: state_d = ST_W1;
            ST_W1:  state_d = ST_W2;
            ST_W2: begin
                if (o_q == 4'(N_OUT - 1)) begin
                    state_d = ST_TAIL;
                end else begin
                    o_d     = o_q + 4'd1;
                    state_d = ST_CLR;
                end
            end
            ST_TAIL: begin
                if (done_o) begin
                    state_d = ST_IDLE;
                    o_d     = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mac_clear_d = (state_q == ST_CLR);
        mac_en_d    = (state_q == ST_RD);
        mac_valid_d = (state_q == ST_VLD);
        vld_idx_d   = (state_q == ST_VLD) ? o_q : 4'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            o_q         <= '0;
            w_addr_q    <= '0;
            busy_q      <= 1'b0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_valid_q <= 1'b0;
            vld_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            o_q         <= o_d;
            w_addr_q    <= w_addr_d;
            busy_q      <= busy_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
            mac_valid_q <= mac_valid_d;
            vld_idx_q   <= vld_idx_d;
        end
    end

    mac_feeder_dly #(
        .W (5),
        .D (RES_LAT)
    ) u_res_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({mac_valid_q, vld_idx_q}),
        .q_o   (res_dly)
    );

    assign busy_o        = busy_q;
    assign img_rd_o      = (state_q == ST_RD);
    assign w_rd_o        = (state_q == ST_RD);
    assign img_addr_o    = k_q;
    assign w_addr_o      = w_addr_q;
    assign mac_clear_o   = mac_clear_q;
    assign mac_en_o      = mac_en_q;
    assign mac_valid_o   = mac_valid_q;
    assign image_data_o  = mac_en_q ? img_q_i : 8'd0;
    assign weight_data_o = mac_en_q ? w_q_i : 8'd0;
    assign res_valid_o   = res_dly[4];
    assign res_idx_o     = res_dly[3:0];
    assign done_o        = res_dly[4] && (res_dly[3:0] == 4'(N_OUT - 1));

`ifdef MAC_FEEDER_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE && start_i) begin
            perf_d = '0;
        end else if (busy_q && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder (K_LEN=4, N_OUT=2) with ROM and MAC models
module tb_mac_feeder;

    localparam int K = 4;
    localparam int N = 2;
    localparam int P = K + 4;

    logic       clk = 1'b0;
    logic       rst_i, start_i;
    logic       busy_o, done_o, img_rd_o, w_rd_o;
    logic [1:0] img_addr_o;
    logic [2:0] w_addr_o;
    logic [7:0] img_q, w_q;
    logic       mac_en_o, mac_valid_o, mac_clear_o, res_valid_o;
    logic [7:0] image_data_o, weight_data_o;
    logic [3:0] res_idx_o;
`ifdef MAC_FEEDER_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    always #5 clk = ~clk;

    mac_feeder #(.K_LEN(K), .N_OUT(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .img_rd_o      (img_rd_o),
        .img_addr_o    (img_addr_o),
        .img_q_i       (img_q),
        .w_rd_o        (w_rd_o),
        .w_addr_o      (w_addr_o),
        .w_q_i         (w_q),
        .mac_en_o      (mac_en_o),
        .mac_valid_o   (mac_valid_o),
        .mac_clear_o   (mac_clear_o),
        .image_data_o  (image_data_o),
        .weight_data_o (weight_data_o),
`ifdef MAC_FEEDER_PERF_EN
        .perf_cycles_o (perf_cycles_o),
`endif
        .res_valid_o   (res_valid_o),
        .res_idx_o     (res_idx_o)
    );

    logic [7:0] img_mem [K];
    logic [7:0] w_mem [K*N];

    always @(posedge clk) begin
        if (img_rd_o) img_q <= img_mem[img_addr_o];
        if (w_rd_o) w_q <= w_mem[w_addr_o];
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int acc;
    int cap_q[$];
    int exp_res [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // mode 0: directed dot products, 1/2: signed extremes, 3: random bytes
    task automatic fill(input int mode);
        for (int k = 0; k < K; k++) begin
            case (mode)
                0: img_mem[k] = 8'(k + 1);
                1: img_mem[k] = 8'h80;
                2: img_mem[k] = 8'h7F;
                default: img_mem[k] = 8'($urandom);
            endcase
        end
        for (int i = 0; i < K*N; i++) begin
            case (mode)
                0: w_mem[i] = (i < K) ? 8'd1 : ((i % 2 == 0) ? 8'(-(i - K + 1)) : 8'(i - K + 1));
                1, 2: w_mem[i] = 8'h80;
                default: w_mem[i] = 8'($urandom);
            endcase
        end
        for (int n = 0; n < N; n++) begin
            exp_res[n] = 0;
            for (int k = 0; k < K; k++) begin
                exp_res[n] += int'($signed(img_mem[k])) * int'($signed(w_mem[n*K + k]));
            end
        end
    endtask

    task automatic sample(input int c, input int rst_c, input string tag, inout int n_res);
        logic [7:0] ev;
        logic [3:0] e_idx;
        logic [7:0] e_img, e_w;
        int  e_ia, e_wa, ia, wa, popped;
        bit  live;
        live  = (rst_c < 0) || (c <= rst_c);
        ev    = '0;
        e_idx = '0;
        e_img = '0;
        e_w   = '0;
        e_ia  = -1;
        e_wa  = 0;
        if (live) begin
            for (int n = 0; n < N; n++) begin
                int b;
                b = P * n;
                if (c == 2 + b) ev[6] = 1'b1;
                if (c >= 2 + b && c <= 1 + K + b) begin
                    ev[5] = 1'b1;
                    ev[4] = 1'b1;
                    e_ia = c - 2 - b;
                    e_wa = n * K + c - 2 - b;
                end
                if (c >= 3 + b && c <= 2 + K + b) begin
                    ev[3] = 1'b1;
                    e_img = img_mem[c - 3 - b];
                    e_w   = w_mem[n*K + c - 3 - b];
                end
                if (c == 3 + K + b) ev[2] = 1'b1;
                if (c == 6 + K + b) begin
                    ev[1] = 1'b1;
                    e_idx = 4'(n);
                    if (n == N - 1) ev[0] = 1'b1;
                end
            end
            if (c >= 1 && c <= 6 + K + P*(N-1)) ev[7] = 1'b1;
        end
        check($sformatf("%s c%0d ctrl", tag, c),
              {busy_o, mac_clear_o, img_rd_o, w_rd_o, mac_en_o, mac_valid_o, res_valid_o, done_o}, ev);
        check($sformatf("%s c%0d idx", tag, c), res_idx_o, e_idx);
        check($sformatf("%s c%0d ops", tag, c), {image_data_o, weight_data_o}, {e_img, e_w});
        if (e_ia >= 0) begin
            check($sformatf("%s c%0d addr", tag, c), {img_addr_o, w_addr_o}, {2'(e_ia), 3'(e_wa)});
        end
        if (!live) begin
            check($sformatf("%s c%0d rstaddr", tag, c), {img_addr_o, w_addr_o}, 5'd0);
            cap_q.delete();
            acc = 0;
        end
        // MAC model: result capture seen first, then clear, accumulate, capture request
        if (res_valid_o) begin
            n_res++;
            check($sformatf("%s c%0d capq", tag, c), cap_q.size() != 0, 1'b1);
            if (cap_q.size() != 0) begin
                popped = cap_q.pop_front();
                check($sformatf("%s c%0d result", tag, c), popped, exp_res[e_idx]);
            end
        end
        if (mac_clear_o) acc = 0;
        if (mac_en_o) begin
            ia = $signed(image_data_o);
            wa = $signed(weight_data_o);
            acc += ia * wa;
        end
        if (mac_valid_o) cap_q.push_back(acc);
    endtask

    task automatic run(input int ncyc, input int s1, input int s2, input int rst_c, input string tag);
        int n_res;
        n_res = 0;
        acc = 0;
        cap_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start_i = (c == 0) || (c == s1) || (c == s2);
            rst_i   = (c == rst_c);
            @(negedge clk);
            sample(c, rst_c, tag, n_res);
        end
        start_i = 1'b0;
        rst_i   = 1'b0;
        check({tag, " nres"}, n_res, (rst_c < 0) ? N : 0);
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        img_q   = '0;
        w_q     = '0;
        fill(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              {busy_o, done_o, img_rd_o, img_addr_o, w_rd_o, w_addr_o, mac_en_o, mac_valid_o,
               mac_clear_o, image_data_o, weight_data_o, res_valid_o, res_idx_o}, '0);
        rst_i = 1'b0;

        run(24, -1, -1, -1, "t1");
`ifdef MAC_FEEDER_PERF_EN
        check("perf t1", perf_cycles_o, 32'd18);
`endif
        fill(1);
        run(24, -1, -1, -1, "t3neg");
        fill(2);
        run(24, -1, -1, -1, "t3mix");
        fill(0);
        run(24, 5, 18, -1, "t4");
        run(24, -1, -1, 8, "t5rst");
`ifdef MAC_FEEDER_PERF_EN
        check("perf rst", perf_cycles_o, 32'd0);
`endif
        run(24, -1, -1, -1, "t5again");
        for (int r = 0; r < 3; r++) begin
            fill(3);
            run(24, -1, -1, -1, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
